pow_root: RTL

Integer fifth-root engine on the AXI-Stream path: the inverse of the x^5 power pipeline. It accepts one 32-bit word, computes floor(x^(1/5)) by bit-serial binary search with a single iterated multiplier, and returns the result with the transaction ID. It sits downstream of the power stage, or on a return path, to recover operands from power results.

---
 rtl/pow_root_if.sv | 31 +++
 rtl/pow_root.sv | 119 +++++++++++
 2 files changed

// File: rtl/pow_root_if.sv
// Stream bundle for the fifth-root engine: operand input (s_*) and result output (m_*).
// m_texact exists only when POW_ROOT_EXACT_EN is defined.
interface pow_root_if;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] s_tdata;
    logic        s_tid;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic        m_tid;
`ifdef POW_ROOT_EXACT_EN
    logic        m_texact;
`endif

    modport slave (
        input  s_tvalid, s_tdata, s_tid, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tid
`ifdef POW_ROOT_EXACT_EN
        , output m_texact
`endif
    );

    modport master (
        output s_tvalid, s_tdata, s_tid, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tid
`ifdef POW_ROOT_EXACT_EN
        , input m_texact
`endif
    );
endinterface

// File: rtl/pow_root.sv
// Integer fifth root, floor(x^(1/5)), by bit-serial binary search over 7 result bits
// using one iterated 7x35 multiplier. Optional POW_ROOT_EXACT_EN adds m_texact.
module pow_root (
    input  logic     clk,
    input  logic     areset,
    pow_root_if.slave io
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] x_q, x_d;
    logic        tid_q, tid_d;
    logic [6:0]  root_q, root_d;
    logic [2:0]  b_q, b_d;
    logic [1:0]  step_q, step_d;
    logic [34:0] p_q, p_d;
    logic [6:0]  cand;
    logic [34:0] mul_b, prod;
`ifdef POW_ROOT_EXACT_EN
    logic [34:0] pow5_q, pow5_d;
    logic        exact_q, exact_d;
`endif

    // Step 0 squares the candidate; later steps fold one more factor into p.
    // c^5 <= 127^5 fits in 35 bits, so the product never truncates.
    assign cand  = root_q | (7'd1 << b_q);
    assign mul_b = (step_q == 2'd0) ? {28'd0, cand} : p_q;
    assign prod  = mul_b * {28'd0, cand};

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        tid_d   = tid_q;
        root_d  = root_q;
        b_d     = b_q;
        step_d  = step_q;
        p_d     = p_q;
`ifdef POW_ROOT_EXACT_EN
        pow5_d  = pow5_q;
        exact_d = exact_q;
`endif
        case (state_q)
            IDLE: begin
                if (io.s_tvalid) begin
                    x_d     = io.s_tdata;
                    tid_d   = io.s_tid;
                    root_d  = 7'd0;
                    b_d     = 3'd6;
                    step_d  = 2'd0;
                    state_d = CALC;
`ifdef POW_ROOT_EXACT_EN
                    pow5_d  = 35'd0;
                    exact_d = 1'b0;
`endif
                end
            end
            CALC: begin
                p_d    = prod;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    if (prod <= {3'd0, x_q}) begin
                        root_d = cand;
`ifdef POW_ROOT_EXACT_EN
                        pow5_d = prod;
`endif
                    end
                    if (b_q == 3'd0) begin
                        state_d = DONE;
`ifdef POW_ROOT_EXACT_EN
                        exact_d = (pow5_d == {3'd0, x_q});
`endif
                    end else begin
                        b_d = b_q - 3'd1;
                    end
                end
            end
            DONE: begin
                if (io.m_tready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            x_q     <= 32'd0;
            tid_q   <= 1'b0;
            root_q  <= 7'd0;
            b_q     <= 3'd0;
            step_q  <= 2'd0;
            p_q     <= 35'd0;
`ifdef POW_ROOT_EXACT_EN
            pow5_q  <= 35'd0;
            exact_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            tid_q   <= tid_d;
            root_q  <= root_d;
            b_q     <= b_d;
            step_q  <= step_d;
            p_q     <= p_d;
`ifdef POW_ROOT_EXACT_EN
            pow5_q  <= pow5_d;
            exact_q <= exact_d;
`endif
        end
    end

    assign io.s_tready = (state_q == IDLE);
    assign io.m_tvalid = (state_q == DONE);
    assign io.m_tdata  = {25'd0, root_q};
    assign io.m_tid    = tid_q;
`ifdef POW_ROOT_EXACT_EN
    assign io.m_texact = exact_q;
`endif
endmodule
